// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: one outstanding request,
// byte-addressed little-endian storage, fixed programmable latency, stallable response.
module dmem_responder #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [3:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // req_ready is high only in IDLE; resp_valid stays high with stable data until taken.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [63:0]   addr_q, addr_d;
  logic [3:0]    size_q, size_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [7:0]    mem_q [DEPTH_BYTES];

  logic          size_ok;
  logic          align_ok;
  logic          range_ok;
  logic          req_err;
  logic          access;
  logic [AW-1:0] base;
  logic [63:0]   rd_data;

  // Range test is written as addr <= DEPTH - size so it cannot wrap at 64 bits.
  assign size_ok  = (size_q == 4'd1) || (size_q == 4'd2) || (size_q == 4'd4) || (size_q == 4'd8);
  assign align_ok = (addr_q & {60'd0, size_q - 4'd1}) == 64'd0;
  assign range_ok = addr_q <= (64'(DEPTH_BYTES) - {60'd0, size_q});
  assign req_err  = !(size_ok && align_ok && range_ok);

  assign access = (state_q == S_WAIT) && (cnt_q == '0);
  assign base   = addr_q[AW-1:0];

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(size_q)) rd_data[8*k +: 8] = mem_q[base + AW'(k)];
    end
  end

  // Storage is deliberately not reset; writes only happen on a legal store's access edge.
  always_ff @(posedge clk) begin
    if (access && write_q && !req_err) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(size_q)) mem_q[base + AW'(k)] <= wdata_q[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          err_d        = req_err;
          rdata_d      = (req_err || write_q) ? 64'd0 : rd_data;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          rdata_d      = '0;
          err_d        = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reset, loads/stores, partial stores, errors,
// back-pressure and reset during an in-flight store.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [3:0]  req_size = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Driver: issues one request with resp_ready high, returns response and latency
  // (edges from accept to resp_valid), and leaves the DUT back in IDLE.
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [3:0] size,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = {$urandom, $urandom};
    req_size  = 4'($urandom_range(0, 15));
    req_wdata = {$urandom, $urandom};
    n = 0;
    while (n < 20 && !resp_valid) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr=%h: no resp_valid within 20 cycles", addr);
      rdata = '0; err = 1'b0; lat = -1;
    end else begin
      rdata = resp_rdata; err = resp_err; lat = n;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_reset: ready=%b busy=%b valid=%b, need 1 0 0", req_ready, busy, resp_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b need 1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b need 0", resp_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    checks++;
    if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp_data: rdata=%h err=%b need 0 0", resp_rdata, resp_err);
    end
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h10, 4'd8, 64'h1122334455667788, rd, er, lat);
    checks++;
    if (lat != int'(LAT)) begin errors++; $display("FAIL store_latency: got %0d need %0d", lat, LAT); end
    checks++;
    if (er !== 1'b0 || rd !== 64'd0) begin errors++; $display("FAIL store_resp: err=%b rdata=%h need 0 0", er, rd); end
    do_req(1'b0, 64'h10, 4'd8, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h1122334455667788 || er !== 1'b0) begin
      errors++; $display("FAIL load8_0x10: rdata=%h err=%b need 1122334455667788 0", rd, er);
    end
    checks++;
    if (lat != int'(LAT)) begin errors++; $display("FAIL load_latency: got %0d need %0d", lat, LAT); end
  endtask

  task automatic test_partial_store();
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h12, 4'd2, 64'hFFFF_FFFF_FFFF_BEEF, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL store2_err: got %b need 0", er); end
    do_req(1'b0, 64'h10, 4'd8, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h11223344BEEF7788) begin errors++; $display("FAIL partial_load8: got %h need 11223344beef7788", rd); end
    do_req(1'b0, 64'h13, 4'd1, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'hBE || er !== 1'b0) begin errors++; $display("FAIL load1_0x13: rdata=%h err=%b need be 0", rd, er); end
    do_req(1'b0, 64'h14, 4'd4, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h11223344) begin errors++; $display("FAIL load4_0x14: got %h need 11223344", rd); end
  endtask

  task automatic test_errors();
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h0, 4'd8, 64'h0123456789ABCDEF, rd, er, lat);
    do_req(1'b0, 64'h2, 4'd4, 64'd0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 64'd0 || lat != int'(LAT)) begin
      errors++; $display("FAIL err_misaligned_load: err=%b rdata=%h lat=%0d need 1 0 %0d", er, rd, lat, LAT);
    end
    do_req(1'b1, 64'h0, 4'd3, 64'hDEADBEEF_DEADBEEF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL err_size3_store: err=%b rdata=%h need 1 0", er, rd); end
    do_req(1'b1, 64'h4, 4'd8, 64'hDEADBEEF_DEADBEEF, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL err_misaligned_store: err=%b need 1", er); end
    do_req(1'b0, 64'h0, 4'd8, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h0123456789ABCDEF || er !== 1'b0) begin
      errors++; $display("FAIL err_no_commit: rdata=%h err=%b need 0123456789abcdef 0", rd, er);
    end
    do_req(1'b1, 64'(DEPTH - 4), 4'd4, 64'h1111_2222_CAFE_F00D, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL top_store4_err: got %b need 0", er); end
    do_req(1'b0, 64'(DEPTH - 4), 4'd8, 64'd0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL err_past_end_load: err=%b rdata=%h need 1 0", er, rd); end
    do_req(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 4'd8, 64'h5555_5555_5555_5555, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL err_wrap_store: err=%b need 1", er); end
    do_req(1'b1, 64'(DEPTH - 8), 4'd8, 64'h7777_7777_7777_7777, rd, er, lat);
    do_req(1'b0, 64'(DEPTH - 4), 4'd4, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h77777777 || er !== 1'b0) begin
      errors++; $display("FAIL top_readback: rdata=%h err=%b need 77777777 0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd; logic er; int lat; int n;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 4'd8; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (n < 20 && !resp_valid) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'h11223344BEEF7788 || resp_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b need 1 11223344beef7788 0", i, resp_valid, resp_rdata, resp_err);
      end
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b need 0", i, req_ready); end
      req_valid = (i % 2) == 0; req_write = 1'b1; req_addr = 64'h10; req_size = 4'd8; req_wdata = 64'd0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 64'd0) begin
      errors++; $display("FAIL bp_release: valid=%b ready=%b rdata=%h need 0 1 0", resp_valid, req_ready, resp_rdata);
    end
    do_req(1'b0, 64'h10, 4'd8, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h11223344BEEF7788) begin errors++; $display("FAIL bp_ignored_store: got %h need 11223344beef7788", rd); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic er; int lat;
    logic [63:0] vals [4];
    vals[0] = 64'hA5; vals[1] = 64'h5A; vals[2] = 64'h3C; vals[3] = 64'hC3;
    for (int i = 0; i < 4; i++) do_req(1'b1, 64'h40 + 64'(i), 4'd1, vals[i], rd, er, lat);
    do_req(1'b0, 64'h40, 4'd4, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'hC33C5AA5) begin errors++; $display("FAIL b2b_bytes: got %h need c33c5aa5", rd); end
    do_req(1'b0, 64'h42, 4'd2, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'hC33C) begin errors++; $display("FAIL b2b_half: got %h need c33c", rd); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_size = 4'd8; req_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b need 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: ready=%b busy=%b valid=%b need 1 0 0", req_ready, busy, resp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 64'h10, 4'd8, 64'd0, rd, er, lat);
    checks++;
    if (rd !== 64'h11223344BEEF7788) begin errors++; $display("FAIL mid_no_commit: got %h need 11223344beef7788", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial_store();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
